// File: rtl/port_arbiter_if.sv
// rtl/port_arbiter_if.sv - request/flit/grant bundle between input ports, arbiter and tx channel
interface port_arbiter_if #(
  parameter int N    = 5,
  parameter int SIZE = 8
);
  logic [N-1:0]      rx_req;
  logic [N-1:0]      rx_ack;
  logic [N*SIZE-1:0] rx_data;
  logic              tx_req;
  logic              tx_ack;
  logic [SIZE-1:0]   tx_data;
  logic [N-1:0]      grant;
  logic              busy;

  modport master (
    output rx_req, rx_data, tx_ack,
    input  rx_ack, tx_req, tx_data, grant, busy
  );

  modport slave (
    input  rx_req, rx_data, tx_ack,
    output rx_ack, tx_req, tx_data, grant, busy
  );
endinterface

// File: rtl/port_arbiter.sv
// rtl/port_arbiter.sv - round-robin, packet-locked scheduler for one router output channel
module port_arbiter #(
  parameter int N            = 5,
  parameter int SIZE         = 8,
  parameter int LOCK_TIMEOUT = 0
) (
  input  logic           clk,
  input  logic           reset,
  port_arbiter_if.slave  bus
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam logic [PW-1:0] LAST_PORT = PW'(N - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'((LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, SEND, LOCK} state_t;

  state_t          state, state_d;
  logic [PW-1:0]   ptr, ptr_d;
  logic [PW-1:0]   win, win_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic [SIZE-1:0] data_q, data_d;
  logic            treq_q, treq_d;
  logic [N-1:0]    ack_q, ack_d;
  logic [N-1:0]    grant_q, grant_d;
  logic            busy_q, busy_d;
  logic [PW-1:0]   pick;
  logic            found;
  logic [PW-1:0]   win_next;

  // Scan from the highest offset down so the lowest offset from ptr is the last write and wins.
  always_comb begin
    pick  = ptr;
    found = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      int t;
      t = int'(ptr) + k;
      if (t >= N) t = t - N;
      if (bus.rx_req[t]) begin
        pick  = PW'(t);
        found = 1'b1;
      end
    end
  end

  assign win_next = (win == LAST_PORT) ? '0 : win + 1'b1;

  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    win_d   = win;
    cnt_d   = cnt;
    data_d  = data_q;
    treq_d  = treq_q;
    ack_d   = '0;
    grant_d = grant_q;
    case (state)
      IDLE: begin
        if (found) begin
          win_d       = pick;
          data_d      = bus.rx_data[int'(pick)*SIZE +: SIZE];
          treq_d      = 1'b1;
          ack_d[pick] = 1'b1;
          grant_d     = '0;
          grant_d[pick] = 1'b1;
          state_d     = SEND;
        end
      end
      SEND: begin
        if (bus.tx_ack) begin
          treq_d = 1'b0;
          if (data_q[SIZE-1]) begin
            ptr_d   = win_next;
            grant_d = '0;
            state_d = IDLE;
          end else begin
            cnt_d   = '0;
            state_d = LOCK;
          end
        end
      end
      LOCK: begin
        if (bus.rx_req[win]) begin
          data_d     = bus.rx_data[int'(win)*SIZE +: SIZE];
          treq_d     = 1'b1;
          ack_d[win] = 1'b1;
          state_d    = SEND;
        end else if (LOCK_TIMEOUT > 0) begin
          // Truncated packet: give the channel back rather than stall everyone behind it.
          if (cnt == CNT_LAST) begin
            ptr_d   = win_next;
            grant_d = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr     <= '0;
      win     <= '0;
      cnt     <= '0;
      data_q  <= '0;
      treq_q  <= 1'b0;
      ack_q   <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      ptr     <= ptr_d;
      win     <= win_d;
      cnt     <= cnt_d;
      data_q  <= data_d;
      treq_q  <= treq_d;
      ack_q   <= ack_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.tx_data = data_q;
  assign bus.tx_req  = treq_q;
  assign bus.rx_ack  = ack_q;
  assign bus.grant   = grant_q;
  assign bus.busy    = busy_q;
endmodule

// File: tb/tb_port_arbiter.sv
// tb/tb_port_arbiter.sv - scoreboard bench for port_arbiter against a packet-level reference model
module tb_port_arbiter;
  localparam int N    = 5;
  localparam int SIZE = 8;
  localparam int TO   = 3;

  typedef struct { int port; logic [SIZE-1:0] flit; } xfer_t;
  typedef struct { int port; int cyc; } ack_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [SIZE-1:0] pq [N][$];
  logic [N-1:0]    en = '0;
  int              ack_mode = 1;
  xfer_t           exp_q[$];
  ack_t            ack_q[$];

  // Reference model: who owns the channel, whether a flit is buffered, rotation start, idle count.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_cnt   = 0;
  bit m_inflight = 1'b0;
  bit m_tail     = 1'b0;

  always #5 clk = ~clk;

  port_arbiter_if #(.N(N), .SIZE(SIZE)) bus ();

  port_arbiter #(.N(N), .SIZE(SIZE), .LOCK_TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endfunction

  task automatic model_clear();
    m_owner = -1; m_ptr = 0; m_cnt = 0; m_inflight = 1'b0; m_tail = 1'b0;
    exp_q.delete();
    ack_q.delete();
  endtask

  task automatic capture(input int p);
    logic [SIZE-1:0] f;
    f = pq[p].pop_front();
    m_owner    = p;
    m_inflight = 1'b1;
    m_tail     = f[SIZE-1];
    exp_q.push_back('{p, f});
    ack_q.push_back('{p, cyc});
  endtask

  task automatic model_step();
    if (m_inflight) begin
      if (bus.tx_ack) begin
        m_inflight = 1'b0;
        if (m_tail) begin
          m_ptr = (m_owner + 1) % N;
          m_owner = -1;
        end else begin
          m_cnt = 0;
        end
      end
    end else if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        if (bus.rx_req[(m_ptr + k) % N]) begin
          capture((m_ptr + k) % N);
          break;
        end
      end
    end else begin
      if (bus.rx_req[m_owner]) capture(m_owner);
      else begin
        m_cnt++;
        if (m_cnt == TO) begin
          m_ptr = (m_owner + 1) % N;
          m_owner = -1;
        end
      end
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.rx_req[i] = en[i] && (pq[i].size() > 0);
      bus.rx_data[i*SIZE +: SIZE] = (pq[i].size() > 0) ? pq[i][0] : '0;
    end
    case (ack_mode)
      0:       bus.tx_ack = ($urandom_range(0, 9) < 6);
      1:       bus.tx_ack = 1'b1;
      default: bus.tx_ack = 1'b0;
    endcase
  endtask

  task automatic randomize_sources();
    for (int i = 0; i < N; i++) begin
      if (pq[i].size() == 0 && $urandom_range(0, 3) == 0) begin
        int len;
        len = $urandom_range(1, 4);
        for (int j = 0; j < len; j++) begin
          logic [SIZE-1:0] f;
          f = SIZE'($urandom);
          f[SIZE-1] = (j == len - 1);
          pq[i].push_back(f);
        end
      end
      en[i] = ($urandom_range(0, 9) < 7);
    end
  endtask

  task automatic tick(input bit rnd);
    @(posedge clk);
    cyc++;
    if (!reset) model_step();
    #1;
    if (rnd) randomize_sources();
    drive();
  endtask

  task automatic run(input int n);
    repeat (n) tick(1'b0);
  endtask

  always @(negedge clk) begin
    logic [N-1:0] exp_ack;
    logic [N-1:0] exp_grant;
    exp_ack = '0;
    if (ack_q.size() > 0 && ack_q[0].cyc == cyc) begin
      exp_ack[ack_q[0].port] = 1'b1;
      void'(ack_q.pop_front());
    end
    exp_grant = '0;
    if (m_owner >= 0) exp_grant[m_owner] = 1'b1;
    chk("rx_ack",  32'(bus.rx_ack), 32'(exp_ack));
    chk("grant",   32'(bus.grant),  32'(exp_grant));
    chk("tx_req",  32'(bus.tx_req), 32'(m_inflight));
    chk("busy",    32'(bus.busy),   32'(m_owner >= 0));
    if (bus.tx_req && exp_q.size() > 0)
      chk("tx_data_hold", 32'(bus.tx_data), 32'(exp_q[0].flit));
    if (bus.tx_req && bus.tx_ack) begin
      if (exp_q.size() == 0) begin
        chk("xfer_unexpected", 32'(1), 32'(0));
      end else begin
        xfer_t x;
        x = exp_q.pop_front();
        chk("xfer_data", 32'(bus.tx_data), 32'(x.flit));
        chk("xfer_port", 32'(bus.grant), 32'(1) << x.port);
      end
    end
  end

  initial begin
    ack_mode = 1;
    drive();
    repeat (3) tick(1'b0);
    reset = 1'b0;

    // Single tail flit from port 2; rotation then starts at 3.
    pq[2].push_back(8'h81);
    en = 5'b00100; drive();
    run(6);

    // Every port requesting single-flit packets: strict rotation.
    for (int i = 0; i < N; i++) begin
      pq[i].push_back(8'h80 | 8'(i));
      pq[i].push_back(8'hC0 | 8'(i));
    end
    en = 5'b11111; drive();
    run(30);

    // Three-flit packet on port 1 must not be interleaved with port 0.
    pq[1].push_back(8'h01); pq[1].push_back(8'h02); pq[1].push_back(8'h83);
    for (int j = 0; j < 3; j++) pq[0].push_back(8'h90);
    en = 5'b00011; drive();
    run(20);

    // Back-pressure: tx_ack low for several cycles holds the flit.
    pq[3].push_back(8'hA5);
    en = 5'b01000; ack_mode = 2; drive();
    run(6);
    ack_mode = 1; drive();
    run(4);

    // Non-tail flit then silence on port 4: lock times out and port 0 gets the channel.
    pq[4].push_back(8'h10);
    pq[0].push_back(8'h81);
    en = 5'b10001; drive();
    run(15);
    pq[4].push_back(8'h92);
    drive();
    run(6);

    // Asynchronous reset while a flit is waiting for tx_ack.
    pq[2].push_back(8'h03); pq[2].push_back(8'h84);
    pq[1].push_back(8'h81); pq[3].push_back(8'h82);
    en = 5'b01110; ack_mode = 2; drive();
    for (int k = 0; k < 20 && !m_inflight; k++) tick(1'b0);
    chk("reached_send", 32'(bus.tx_req), 32'(1));
    tick(1'b0);
    #1;
    reset = 1'b1;
    model_clear();
    #1;
    chk("rst_tx_req",  32'(bus.tx_req),  32'(0));
    chk("rst_grant",   32'(bus.grant),   32'(0));
    chk("rst_rx_ack",  32'(bus.rx_ack),  32'(0));
    chk("rst_busy",    32'(bus.busy),    32'(0));
    chk("rst_tx_data", 32'(bus.tx_data), 32'(0));
    tick(1'b0);
    reset = 1'b0;
    ack_mode = 1; drive();
    run(12);

    // Random traffic with random gaps and back-pressure.
    ack_mode = 0;
    repeat (1500) tick(1'b1);

    // Drain everything still queued.
    en = 5'b11111; ack_mode = 1; drive();
    run(150);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'(0));
    chk("sources_drained", 32'(pq[0].size() + pq[1].size() + pq[2].size() + pq[3].size() + pq[4].size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
